// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: glyph constants in
// {a,b,c,d,e,f,g} = [6:0] order (1 = lit), blink phase type, counter sizing.
package seg7_scan_driver_pkg;

    typedef logic [6:0] glyph_t;

    localparam glyph_t SEG_0     = 7'h7E;
    localparam glyph_t SEG_1     = 7'h30;
    localparam glyph_t SEG_2     = 7'h6D;
    localparam glyph_t SEG_3     = 7'h79;
    localparam glyph_t SEG_4     = 7'h33;
    localparam glyph_t SEG_5     = 7'h5B;
    localparam glyph_t SEG_6     = 7'h5F;
    localparam glyph_t SEG_7     = 7'h70;
    localparam glyph_t SEG_8     = 7'h7F;
    localparam glyph_t SEG_9     = 7'h7B;
    localparam glyph_t SEG_BLANK = 7'h00;

    // Code held in the digit registers after reset; decodes to a blank glyph.
    localparam logic [3:0] CODE_DARK = 4'hF;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_phase_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: BCD/load/mask controls in, segment/anode/frame out.
// The driver is the slave; the floor/status logic is the master.
interface seg7_scan_driver_if
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic                lzs;
    glyph_t              seg_7;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport master (
        output bcd, load, blank_mask, blink_mask, lzs,
        input  seg_7, an, frame
    );

    modport slave (
        input  bcd, load, blank_mask, blink_mask, lzs,
        output seg_7, an, frame
    );
endinterface

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD-to-glyph decoder; codes A..F render as a blank digit.
module seg7_scan_driver_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] code_i,
    output glyph_t     glyph_o
);

    // Table lookup from digit code to segment pattern.
    always_comb begin
        case (code_i)
            4'd0:    glyph_o = SEG_0;
            4'd1:    glyph_o = SEG_1;
            4'd2:    glyph_o = SEG_2;
            4'd3:    glyph_o = SEG_3;
            4'd4:    glyph_o = SEG_4;
            4'd5:    glyph_o = SEG_5;
            4'd6:    glyph_o = SEG_6;
            4'd7:    glyph_o = SEG_7;
            4'd8:    glyph_o = SEG_8;
            4'd9:    glyph_o = SEG_9;
            default: glyph_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment bank driver. A shadow register collects BCD
// loads; the active register only takes it at the frame boundary so a frame
// is never torn. One digit is decoded per scan slot, with blanking, blink
// and leading-zero suppression applied before the registered pin outputs.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    seg7_scan_driver_if.slave  bus_io
);

    localparam int PRE_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(DIGITS);
    localparam int BLK_W = cnt_width(BLINK_FRAMES);

    // Pin-level reset values: dark in either polarity.
    localparam glyph_t            SEG_RST = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_RST  = {DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BLK_W-1:0]       blk_cnt_q, blk_cnt_d;
    blink_phase_e           phase_q, phase_d;
    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [DIGITS-1:0][3:0] active_q, active_d;
    glyph_t                 seg_q, seg_d;
    logic [DIGITS-1:0]      an_q, an_d;

    logic                   scan_tick;
    logic                   frame_tick;
    logic [DIGITS-1:0]      lead_zero;
    logic [3:0]             cur_code;
    glyph_t                 cur_glyph;
    logic                   cur_dark;

    // Scan timing, blink phase and BCD capture next-state logic.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        scan_tick  = (pre_q == PRE_W'(SCAN_DIV - 1));
        frame_tick = scan_tick && (idx_q == IDX_W'(DIGITS - 1));
        pre_d      = scan_tick ? '0 : pre_q + PRE_W'(1);
        idx_d      = idx_q;
        blk_cnt_d  = blk_cnt_q;
        phase_d    = phase_q;
        shadow_d   = bus_io.load ? bus_io.bcd : shadow_q;
        active_d   = active_q;

        if (scan_tick) begin
            idx_d = frame_tick ? '0 : idx_q + IDX_W'(1);
        end

        if (frame_tick) begin
            // A load landing on the boundary goes straight to the display.
            active_d = bus_io.load ? bus_io.bcd : shadow_q;
            if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_cnt_d = '0;
                phase_d   = (phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    // Leading-zero map: bit k set when active digits k..DIGITS-1 are all zero.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero && (active_q[k] == 4'h0);
            lead_zero[k] = all_zero;
        end
    end

    // Darkness mux and output encoding for the digit currently selected.
    always_comb begin
        cur_code = active_q[idx_q];
        cur_dark = bus_io.blank_mask[idx_q]
                || (bus_io.blink_mask[idx_q] && (phase_q == BLINK_OFF))
                || (bus_io.lzs && (idx_q != '0) && lead_zero[idx_q]);
        seg_d    = cur_dark ? SEG_BLANK : cur_glyph;
        an_d     = DIGITS'(1) << idx_q;
        if (ACTIVE_LOW) begin
            seg_d = ~seg_d;
            an_d  = ~an_d;
        end
    end

    seg7_scan_driver_decode u_decode (
        .code_i  (cur_code),
        .glyph_o (cur_glyph)
    );

    // State and pin registers; reset drives everything dark immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst_i) begin
            pre_q     <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            phase_q   <= BLINK_ON;
            shadow_q  <= {DIGITS{CODE_DARK}};
            active_q  <= {DIGITS{CODE_DARK}};
            seg_q     <= SEG_RST;
            an_q      <= AN_RST;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus_io.seg_7 = seg_q;
    assign bus_io.an    = an_q;
    assign bus_io.frame = frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: one active-high-pin instance (A) and one
// active-low-pin instance (B). Stimulus pushes the expected {an, seg} of each
// scan slot into a per-instance queue; monitors pop on every anode change.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    seg7_scan_driver_if #(.DIGITS(4)) bus_a ();
    seg7_scan_driver_if #(.DIGITS(4)) bus_b ();

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk_i  (clk),
        .rst_i  (rst_a),
        .bus_io (bus_a)
    );

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk_i  (clk),
        .rst_i  (rst_b),
        .bus_io (bus_b)
    );

    int checks = 0;
    int errors = 0;

    logic [10:0] sb_a[$];
    logic [10:0] sb_b[$];
    bit          en_a = 1'b0;
    bit          en_b = 1'b0;
    logic [3:0]  prev_a = 4'h0;
    logic [3:0]  prev_b = 4'hF;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A: one scoreboard entry per scan slot.
    always @(negedge clk) begin
        logic [10:0] e;
        if (bus_a.an !== prev_a) begin
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                check("scan_a", {5'b0, bus_a.an, bus_a.seg_7}, {5'b0, e});
            end else if (en_a) begin
                checks++;
                errors++;
                $display("FAIL scan_a_extra: got an=%b seg=%h expected no output", bus_a.an, bus_a.seg_7);
            end
        end
        prev_a <= bus_a.an;
    end

    // Monitor B: raw (inverted) pin values.
    always @(negedge clk) begin
        logic [10:0] e;
        if (bus_b.an !== prev_b) begin
            if (sb_b.size() != 0) begin
                e = sb_b.pop_front();
                check("scan_b", {5'b0, bus_b.an, bus_b.seg_7}, {5'b0, e});
            end else if (en_b) begin
                checks++;
                errors++;
                $display("FAIL scan_b_extra: got an=%b seg=%h expected no output", bus_b.an, bus_b.seg_7);
            end
        end
        prev_b <= bus_b.an;
    end

    function automatic logic frame_of(input bit b);
        return b ? bus_b.frame : bus_a.frame;
    endfunction

    task automatic set_load(input bit b, input logic [15:0] v, input logic l);
        if (b) begin
            bus_b.bcd  = v;
            bus_b.load = l;
        end else begin
            bus_a.bcd  = v;
            bus_a.load = l;
        end
    endtask

    // Expected pre-invert glyphs for digits 0..3 of one frame.
    task automatic push(input bit b, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            logic [3:0] an_v;
            an_v = 4'b0001 << k;
            if (b) sb_b.push_back({~an_v, ~s[k]});
            else   sb_a.push_back({an_v, s[k]});
        end
    endtask

    // Wait for the FRAME cycle, optionally load on it, then step past the boundary.
    task automatic boundary(input bit b, input bit do_load, input logic [15:0] v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_of(b) && n < 40);
        if (!frame_of(b)) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no FRAME pulse within %0d cycles expected one", n);
        end
        if (do_load) set_load(b, v, 1'b1);
        @(negedge clk);
        set_load(b, v, 1'b0);
        check(b ? "frame_width_b" : "frame_width_a", {15'b0, frame_of(b)}, 16'h0000);
    endtask

    task automatic load_mid(input bit b, input logic [15:0] v);
        repeat (4) @(negedge clk);
        set_load(b, v, 1'b1);
        @(negedge clk);
        set_load(b, v, 1'b0);
    endtask

    task automatic drain(input bit b);
        int n;
        n = 0;
        while ((b ? sb_b.size() : sb_a.size()) > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(b ? "drain_b" : "drain_a", 16'(b ? sb_b.size() : sb_a.size()), 16'h0000);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.bcd = '0; bus_a.load = 1'b0; bus_a.blank_mask = '0; bus_a.blink_mask = '0; bus_a.lzs = 1'b0;
        bus_b.bcd = '0; bus_b.load = 1'b0; bus_b.blank_mask = '0; bus_b.blink_mask = '0; bus_b.lzs = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_seg_a",   {9'b0, bus_a.seg_7}, 16'h0000);
        check("rst_an_a",    {12'b0, bus_a.an},   16'h0000);
        check("rst_frame_a", {15'b0, bus_a.frame}, 16'h0000);
        check("rst_seg_b",   {9'b0, bus_b.seg_7}, 16'h007F);
        check("rst_an_b",    {12'b0, bus_b.an},   16'h000F);

        // Frame 0/1: nothing loaded, all digits dark while AN walks.
        push(0, 7'h00, 7'h00, 7'h00, 7'h00);
        en_a  = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        boundary(0, 0, 16'h0);
        push(0, 7'h00, 7'h00, 7'h00, 7'h00);
        load_mid(0, 16'h1234);                        // held back until next frame
        boundary(0, 0, 16'h0);
        push(0, 7'h33, 7'h79, 7'h6D, 7'h30);          // frame 2: 4,3,2,1
        load_mid(0, 16'h0007);
        boundary(0, 0, 16'h0);
        bus_a.lzs = 1'b1;
        push(0, 7'h70, 7'h00, 7'h00, 7'h00);          // frame 3: LZS on 0007
        load_mid(0, 16'h0000);
        boundary(0, 0, 16'h0);
        push(0, 7'h7E, 7'h00, 7'h00, 7'h00);          // frame 4: digit 0 never suppressed
        load_mid(0, 16'h0008);
        boundary(0, 0, 16'h0);
        bus_a.lzs = 1'b0;
        bus_a.blink_mask = 4'b0001;
        push(0, 7'h7F, 7'h7E, 7'h7E, 7'h7E);          // frame 5: blink ON
        boundary(0, 0, 16'h0);
        push(0, 7'h00, 7'h7E, 7'h7E, 7'h7E);          // frame 6: blink OFF
        boundary(0, 0, 16'h0);
        push(0, 7'h00, 7'h7E, 7'h7E, 7'h7E);          // frame 7: blink OFF
        boundary(0, 0, 16'h0);
        push(0, 7'h7F, 7'h7E, 7'h7E, 7'h7E);          // frame 8: blink ON
        boundary(0, 1, 16'h9999);                     // LOAD on the FRAME cycle
        bus_a.blink_mask = 4'b0000;
        push(0, 7'h7B, 7'h7B, 7'h7B, 7'h7B);          // frame 9: bypass
        boundary(0, 0, 16'h0);
        push(0, 7'h7B, 7'h7B, 7'h7B, 7'h7B);          // frame 10: shadow also took it
        load_mid(0, 16'h6CE2);
        boundary(0, 0, 16'h0);
        bus_a.blank_mask = 4'b0001;
        push(0, 7'h00, 7'h00, 7'h00, 7'h5F);          // frame 11: blank d0, codes E/C dark
        load_mid(0, 16'h0500);
        boundary(0, 0, 16'h0);
        bus_a.blank_mask = 4'b0000;
        bus_a.lzs = 1'b1;
        push(0, 7'h7E, 7'h7E, 7'h5B, 7'h00);          // frame 12: only d3 is a leading zero
        drain(0);
        en_a = 1'b0;

        // Active-low instance: asynchronous reset mid-scan, LOAD ignored in reset.
        repeat (7) @(negedge clk);
        #2;
        rst_b = 1'b1;
        #1;
        check("async_rst_seg_b",   {9'b0, bus_b.seg_7}, 16'h007F);
        check("async_rst_an_b",    {12'b0, bus_b.an},   16'h000F);
        check("async_rst_frame_b", {15'b0, bus_b.frame}, 16'h0000);
        @(negedge clk);
        set_load(1, 16'h1234, 1'b1);
        repeat (3) @(negedge clk);
        set_load(1, 16'h1234, 1'b0);
        check("rst_hold_an_b", {12'b0, bus_b.an}, 16'h000F);
        @(negedge clk);
        push(1, 7'h00, 7'h00, 7'h00, 7'h00);
        en_b  = 1'b1;
        rst_b = 1'b0;
        boundary(1, 0, 16'h0);
        push(1, 7'h00, 7'h00, 7'h00, 7'h00);          // shadow still dark
        load_mid(1, 16'h000C);
        boundary(1, 0, 16'h0);
        push(1, 7'h00, 7'h7E, 7'h7E, 7'h7E);          // code C dark on enabled digit
        drain(1);
        en_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
